// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: bus width defaults,
// FSM state encoding and the round-robin pick function.
package mem_arbiter_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   // Winner index for a two-way round robin. On a tie the port that was not
   // granted last time wins. A lone requester always wins.
   function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
      if (req0 && req1) begin
         return ~last;
      end
      return req1;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// slave  : arbiter view (takes requests, drives acks and memory strobes)
// master : requester/memory view (drives requests and memory read data)
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output ack0, ack1, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  ack0, ack1, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant selection; purely combinational.
module mem_arbiter_rr
   import mem_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic any_req,
   output logic grant
);

   // Winner is evaluated every cycle; the FSM only consumes it in IDLE.
   always_comb begin
      any_req = req0 | req1;
      grant   = rr_pick(req0, req1, last_grant);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the load/store unit (port 0) and the loader/debug port
// (port 1) in front of a single-port data memory. One transaction every
// three cycles: grant in IDLE, one memory strobe cycle, one ack cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; winner and its command latched here
// ACCESS | memory strobe cycle, mem_read/mem_write driven from latch
// RESP   | ack to the latched winner, rdata forwarded from memory
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
)(
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   arb_state_t        state;
   logic              last_grant;
   logic              win_lat;
   logic              we_lat;
   logic [ADDR_W-1:0] addr_lat;
   logic [DATA_W-1:0] wdata_lat;
   logic              mem_read_q;
   logic              mem_write_q;
   logic              ack0_q;
   logic              ack1_q;

   logic              any_req;
   logic              grant;
   logic              we_sel;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] wdata_sel;

   mem_arbiter_rr u_rr (
      .req0       (bus.req0),
      .req1       (bus.req1),
      .last_grant (last_grant),
      .any_req    (any_req),
      .grant      (grant)
   );

   // Mux the winning requester's command so it can be latched in one step.
   always_comb begin
      we_sel    = grant ? bus.we1    : bus.we0;
      addr_sel  = grant ? bus.addr1  : bus.addr0;
      wdata_sel = grant ? bus.wdata1 : bus.wdata0;
   end

   // Arbiter FSM; strobes and acks are registered so each lines up exactly
   // with the ACCESS and RESP cycles respectively.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         win_lat     <= 1'b0;
         we_lat      <= 1'b0;
         addr_lat    <= '0;
         wdata_lat   <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
      end else begin
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  win_lat     <= grant;
                  last_grant  <= grant;
                  we_lat      <= we_sel;
                  addr_lat    <= addr_sel;
                  wdata_lat   <= wdata_sel;
                  mem_read_q  <= ~we_sel;
                  mem_write_q <= we_sel;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               ack0_q <= ~win_lat;
               ack1_q <= win_lat;
               state  <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The memory registers read data at the end of ACCESS, so it is only
   // meaningful during RESP; zero otherwise so idle rdata is clean.
   always_comb begin
      bus.rdata     = (state == RESP) ? bus.mem_rdata : '0;
      bus.busy      = (state != IDLE);
      bus.ack0      = ack0_q;
      bus.ack1      = ack1_q;
      bus.mem_read  = mem_read_q;
      bus.mem_write = mem_write_q;
      bus.mem_addr  = addr_lat;
      bus.mem_wdata = wdata_lat;
   end

   // Latched write-enable is kept for debug visibility; strobes already encode it.
   logic unused_ok;
   assign unused_ok = we_lat;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural data memory, a scoreboard
// of expected grants/read data, and per-cycle protocol invariants.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   ack0_seen = 0;

   typedef struct {
      logic        port;
      logic        is_read;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   ack_cyc_q[$];

   mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus();

   mem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Data memory: word-indexed, registered read, write on the strobe edge.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr[9:2]];
   end

   // Invariants every cycle, and scoreboard pop on each ack.
   always @(negedge clk) begin
      if (!rst) begin
         tests++;
         if ((bus.mem_read && bus.mem_write) || (bus.ack0 && bus.ack1) ||
             ((bus.mem_read || bus.mem_write) && (!bus.busy || bus.ack0 || bus.ack1))) begin
            fails++;
            $display("FAIL invariant cyc=%0d rd=%b wr=%b ack0=%b ack1=%b busy=%b",
                     cyc, bus.mem_read, bus.mem_write, bus.ack0, bus.ack1, bus.busy);
         end
         if (bus.ack0 || bus.ack1) begin
            ack_cyc_q.push_back(cyc);
            if (bus.ack0) ack0_seen++;
            if (sb_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_ack cyc=%0d ack0=%b ack1=%b", cyc, bus.ack0, bus.ack1);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               tests++;
               if (bus.ack1 !== e.port) begin
                  fails++;
                  $display("FAIL grant_port got=%0d exp=%0d", bus.ack1, e.port);
               end
               if (e.is_read) begin
                  tests++;
                  if (bus.rdata !== e.data) begin
                     fails++;
                     $display("FAIL rdata got=%h exp=%h", bus.rdata, e.data);
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic drive_port(input logic port, input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
      if (port == 1'b0) begin
         bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
      end else begin
         bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
      end
   endtask

   // One isolated transaction from IDLE with cycle-exact checks.
   task automatic do_txn(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd_exp);
      @(negedge clk);
      drive_port(port, 1'b1, we, addr, wdata);
      sb_q.push_back('{port, ~we, rd_exp});
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (bus.mem_write !== we || bus.mem_read !== ~we) begin
         fails++;
         $display("FAIL access_strobe rd=%b wr=%b exp_we=%b", bus.mem_read, bus.mem_write, we);
      end
      tests++;
      if (bus.mem_addr !== addr || (we && bus.mem_wdata !== wdata)) begin
         fails++;
         $display("FAIL access_bus addr=%h exp=%h wdata=%h exp=%h", bus.mem_addr, addr, bus.mem_wdata, wdata);
      end
      @(negedge clk);
      tests++;
      if (bus.ack0 !== ~port || bus.ack1 !== port || bus.mem_read || bus.mem_write) begin
         fails++;
         $display("FAIL resp_ack ack0=%b ack1=%b rd=%b wr=%b port=%0d",
                  bus.ack0, bus.ack1, bus.mem_read, bus.mem_write, port);
      end
      drive_port(port, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      tests++;
      if (bus.busy !== 1'b0 || bus.ack0 || bus.ack1) begin
         fails++;
         $display("FAIL back_to_idle busy=%b ack0=%b ack1=%b", bus.busy, bus.ack0, bus.ack1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if (bus.ack0 || bus.ack1 || bus.busy || bus.mem_read || bus.mem_write) begin
         fails++;
         $display("FAIL reset_ctrl ack0=%b ack1=%b busy=%b rd=%b wr=%b",
                  bus.ack0, bus.ack1, bus.busy, bus.mem_read, bus.mem_write);
      end
      tests++;
      if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.rdata !== 32'h0) begin
         fails++;
         $display("FAIL reset_data addr=%h wdata=%h rdata=%h", bus.mem_addr, bus.mem_wdata, bus.rdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      do_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
      do_txn(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
   endtask

   task automatic test_back_to_back();
      int start;
      int n;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = ack_cyc_q.size();
      sb_q.push_back('{1'b0, 1'b0, 32'h0});
      sb_q.push_back('{1'b1, 1'b0, 32'h0});
      sb_q.push_back('{1'b0, 1'b0, 32'h0});
      sb_q.push_back('{1'b1, 1'b0, 32'h0});
      drive_port(1'b0, 1'b1, 1'b1, 32'h44, 32'h1111);
      drive_port(1'b1, 1'b1, 1'b1, 32'h40, 32'h2222);
      n = 0;
      while (ack_cyc_q.size() < start + 4 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tests++;
      if (ack_cyc_q.size() < start + 4) begin
         fails++;
         $display("FAIL rr_ack_count got=%0d exp=4", ack_cyc_q.size() - start);
      end else begin
         for (int i = 1; i < 4; i++) begin
            tests++;
            if (ack_cyc_q[start+i] - ack_cyc_q[start+i-1] != 3) begin
               fails++;
               $display("FAIL rr_ack_gap idx=%0d got=%0d exp=3", i,
                        ack_cyc_q[start+i] - ack_cyc_q[start+i-1]);
            end
         end
      end
      repeat (4) @(negedge clk);
      tests++;
      if (bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL rr_idle busy=%b exp=0", bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      int acks_before;
      @(negedge clk);
      drive_port(1'b1, 1'b1, 1'b1, 32'h20, 32'h5);
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h20) begin
         fails++;
         $display("FAIL midrst_access wr=%b addr=%h exp wr=1 addr=20", bus.mem_write, bus.mem_addr);
      end
      acks_before = ack_cyc_q.size();
      rst = 1'b1;
      drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      tests++;
      if (bus.busy !== 1'b0 || bus.ack1 !== 1'b0) begin
         fails++;
         $display("FAIL midrst_abort busy=%b ack1=%b exp 0 0", bus.busy, bus.ack1);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      tests++;
      if (ack_cyc_q.size() != acks_before) begin
         fails++;
         $display("FAIL midrst_no_ack got=%0d acks exp=0", ack_cyc_q.size() - acks_before);
      end
      do_txn(1'b0, 1'b0, 32'h20, 32'h0, 32'h5);
   endtask

   task automatic test_port1_only();
      int a0;
      a0 = ack0_seen;
      for (int i = 0; i < 3; i++) begin
         do_txn(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
      end
      tests++;
      if (ack0_seen != a0) begin
         fails++;
         $display("FAIL p1only_ack0 got=%0d exp=0", ack0_seen - a0);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      bus.mem_rdata = 32'h0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_reset_mid();
      test_port1_only();
      repeat (2) @(negedge clk);
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
